// File: rtl/host_cmd_decoder_pkg.sv
// Shared definitions for the host command decoder: FSM states, opcodes and frame-shape helpers.
package host_cmd_decoder_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_TX_START,
      S_TX_WAIT
   } state_e;

   localparam logic [7:0] OP_TRIG_CH     = 8'h01;
   localparam logic [7:0] OP_TRIG_TYPE   = 8'h02;
   localparam logic [7:0] OP_CLK_DIV     = 8'h03;
   localparam logic [7:0] OP_PRECAP      = 8'h04;
   localparam logic [7:0] OP_ARM         = 8'h05;
   localparam logic [7:0] OP_STOP        = 8'h06;
   localparam logic [7:0] OP_READ_STATUS = 8'h07;

   // A rejected write answers with the bitwise inverse of the ACK byte.
   localparam logic [7:0] NAK_MASK = 8'hFF;

   function automatic logic op_valid(input logic [7:0] op);
      return (op >= OP_TRIG_CH) && (op <= OP_READ_STATUS);
   endfunction

   function automatic logic [1:0] payload_len(input logic [7:0] op);
      case (op)
         OP_TRIG_CH, OP_TRIG_TYPE: return 2'd1;
         OP_CLK_DIV, OP_PRECAP:    return 2'd2;
         default:                  return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/host_cmd_decoder.sv
// Parses UART host frames into logic-analyzer configuration registers and control pulses,
// and answers every accepted command with a one-byte reply through the UART TX handshake.
module host_cmd_decoder
   import host_cmd_decoder_pkg::*;
#(
   parameter int         NUM_CH       = 8,
   parameter int         TIMEOUT_CLKS = 4340000,
   parameter logic [7:0] STATUS_ACK   = 8'hA5,
   localparam int        CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int        TO_W         = $clog2(TIMEOUT_CLKS)
) (
   input  logic            i_sys_clk,
   input  logic            i_rst,
   input  logic            i_Rx_DV,
   input  logic [7:0]      i_Rx_Byte,
   input  logic            i_Tx_Done,
   input  logic [7:0]      i_status,
   output logic            o_Tx_DV,
   output logic [7:0]      o_Tx_Byte,
   output logic [CH_W-1:0] o_trig_ch,
   output logic            o_trig_type,
   output logic [15:0]     o_clk_div,
   output logic [15:0]     o_precap,
   output logic            o_arm,
   output logic            o_stop
);

   state_e          state, state_n;
   logic [7:0]      op_q;
   logic [15:0]     shreg;
   logic            byte_cnt;
   logic [TO_W-1:0] to_cnt;
   logic [7:0]      reply_q;

   logic            load_op, shift, commit, expire, last_byte;
   logic [7:0]      cur_op;
   logic [15:0]     payload;

   // The final payload byte is combined live so the commit lands on the edge that samples it.
   assign payload   = {shreg[7:0], i_Rx_Byte};
   assign last_byte = (payload_len(op_q) == 2'd2) ? byte_cnt : 1'b1;
   assign expire    = (to_cnt == TO_W'(TIMEOUT_CLKS - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_n;
   end

   // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_n = state;
      load_op = 1'b0;
      shift   = 1'b0;
      commit  = 1'b0;
      cur_op  = op_q;
      case (state)
         S_IDLE: begin
            cur_op = i_Rx_Byte;
            if (i_Rx_DV && op_valid(i_Rx_Byte)) begin
               load_op = 1'b1;
               if (payload_len(i_Rx_Byte) == 2'd0) begin
                  commit  = 1'b1;
                  state_n = S_TX_START;
               end else begin
                  state_n = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (i_Rx_DV) begin
               shift = 1'b1;
               if (last_byte) begin
                  commit  = 1'b1;
                  state_n = S_TX_START;
               end
            end else if (expire) begin
               state_n = S_IDLE;
            end
         end
         S_TX_START: state_n = S_TX_WAIT;
         S_TX_WAIT:  if (i_Tx_Done) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         op_q        <= 8'h00;
         shreg       <= 16'h0000;
         byte_cnt    <= 1'b0;
         to_cnt      <= '0;
         reply_q     <= 8'h00;
         o_Tx_DV     <= 1'b0;
         o_Tx_Byte   <= 8'h00;
         o_trig_ch   <= '0;
         o_trig_type <= 1'b1;
         o_clk_div   <= 16'd1;
         o_precap    <= 16'd0;
         o_arm       <= 1'b0;
         o_stop      <= 1'b0;
      end else begin
         o_Tx_DV <= 1'b0;
         o_arm   <= 1'b0;
         o_stop  <= 1'b0;

         if (load_op) begin
            op_q     <= i_Rx_Byte;
            byte_cnt <= 1'b0;
         end
         if (shift) begin
            shreg    <= payload;
            byte_cnt <= 1'b1;
         end

         if ((state == S_PAYLOAD) && !i_Rx_DV && !expire) to_cnt <= to_cnt + 1'b1;
         else                                             to_cnt <= '0;

         if (commit) begin
            reply_q <= STATUS_ACK;
            case (cur_op)
               OP_TRIG_CH: begin
                  if (int'(payload[7:0]) < NUM_CH) o_trig_ch <= payload[CH_W-1:0];
                  else                             reply_q   <= STATUS_ACK ^ NAK_MASK;
               end
               OP_TRIG_TYPE: o_trig_type <= payload[0];
               OP_CLK_DIV:   o_clk_div   <= (payload == 16'd0) ? 16'd1 : payload;
               OP_PRECAP:    o_precap    <= payload;
               OP_ARM:       o_arm       <= 1'b1;
               OP_STOP:      o_stop      <= 1'b1;
               default:      ;
            endcase
         end

         // The reply byte is captured once and then held for the whole transmission.
         if (state == S_TX_START) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= (op_q == OP_READ_STATUS) ? i_status : reply_q;
         end
      end
   end

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Directed self-checking bench for host_cmd_decoder; a short timeout keeps the run small.
module tb_host_cmd_decoder;

   localparam int TO_CLKS = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        tx_done = 1'b0;
   logic [7:0]  status = 8'h00;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic [2:0]  trig_ch;
   logic        trig_type;
   logic [15:0] clk_div;
   logic [15:0] precap;
   logic        arm;
   logic        stop;

   int errors = 0;
   int checks = 0;
   int tx_pulses = 0;
   int arm_cycles = 0;
   int stop_cycles = 0;

   host_cmd_decoder #(.NUM_CH(8), .TIMEOUT_CLKS(TO_CLKS), .STATUS_ACK(8'hA5)) dut (
      .i_sys_clk  (clk),
      .i_rst      (rst),
      .i_Rx_DV    (rx_dv),
      .i_Rx_Byte  (rx_byte),
      .i_Tx_Done  (tx_done),
      .i_status   (status),
      .o_Tx_DV    (tx_dv),
      .o_Tx_Byte  (tx_byte),
      .o_trig_ch  (trig_ch),
      .o_trig_type(trig_type),
      .o_clk_div  (clk_div),
      .o_precap   (precap),
      .o_arm      (arm),
      .o_stop     (stop)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_dv) tx_pulses++;
      if (arm)   arm_cycles++;
      if (stop)  stop_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the negedge after the byte's sampling edge, where a commit is already visible.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv   = 1'b0;
   endtask

   // Called right after the final byte: TX request must follow one cycle later, once, and hold.
   task automatic reply(input string tag, input logic [7:0] exp);
      int p0;
      p0 = tx_pulses;
      check({tag, "_dv_not_early"}, tx_dv, 1'b0);
      @(negedge clk);
      check({tag, "_dv"}, tx_dv, 1'b1);
      check({tag, "_byte"}, tx_byte, exp);
      status = ~status;
      idle(4);
      check({tag, "_dv_one_cycle"}, tx_pulses - p0, 1);
      check({tag, "_byte_held"}, tx_byte, exp);
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   initial begin
      int p0, a0, s0;

      idle(3);
      rst = 1'b0;
      check("rst_clk_div", clk_div, 16'd1);
      check("rst_trig_type", trig_type, 1'b1);
      check("rst_trig_ch", trig_ch, 3'd0);
      check("rst_precap", precap, 16'd0);
      check("rst_tx_byte", tx_byte, 8'h00);
      check("rst_arm_stop", {arm, stop}, 2'b00);
      idle(100);
      check("idle_no_tx", tx_pulses, 0);
      check("idle_clk_div", clk_div, 16'd1);

      send(8'h03); send(8'h12); send(8'h34);
      check("clk_div_1234", clk_div, 16'h1234);
      reply("clk_div_ack", 8'hA5);

      send(8'h03); send(8'h00); send(8'h00);
      check("clk_div_zero_as_one", clk_div, 16'd1);
      reply("clk_div0_ack", 8'hA5);

      send(8'h01); send(8'h09);
      check("trig_ch_out_of_range", trig_ch, 3'd0);
      reply("trig_ch_nak", 8'h5A);

      send(8'h01); send(8'h07);
      check("trig_ch_max", trig_ch, 3'd7);
      reply("trig_ch_ack", 8'hA5);

      send(8'h02); send(8'hFE);
      check("trig_type_bit0_low", trig_type, 1'b0);
      reply("trig_type_ack0", 8'hA5);
      send(8'h02); send(8'h03);
      check("trig_type_bit0_high", trig_type, 1'b1);
      reply("trig_type_ack1", 8'hA5);

      a0 = arm_cycles;
      send(8'h05);
      check("arm_at_commit", arm, 1'b1);
      reply("arm_ack", 8'hA5);
      check("arm_one_cycle", arm_cycles - a0, 1);

      status = 8'h3C;
      send(8'h07);
      a0 = arm_cycles;
      fork
         reply("status", 8'h3C);
         begin
            idle(2);
            send(8'h05);
         end
      join
      check("rx_dropped_in_tx", arm_cycles - a0, 0);

      send(8'h08);
      send(8'h00);
      p0 = tx_pulses;
      idle(10);
      check("bad_opcode_no_reply", tx_pulses - p0, 0);
      send(8'h01); send(8'h02);
      check("trig_ch_after_bad_op", trig_ch, 3'd2);
      reply("trig_ch2_ack", 8'hA5);

      send(8'h04); send(8'hAB);
      p0 = tx_pulses;
      idle(TO_CLKS + 5);
      check("timeout_precap", precap, 16'd0);
      check("timeout_no_reply", tx_pulses - p0, 0);
      send(8'h04); send(8'h00); send(8'h10);
      check("precap_16", precap, 16'd16);
      reply("precap_ack", 8'hA5);

      send(8'h04); send(8'h12);
      idle(TO_CLKS - 10);
      send(8'h34);
      check("precap_slow_gap", precap, 16'h1234);
      reply("precap_slow_ack", 8'hA5);

      send(8'h04); send(8'hAB);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      s0 = stop_cycles;
      send(8'h06);
      check("stop_at_commit", stop, 1'b1);
      check("rst_mid_frame_precap", precap, 16'd0);
      reply("stop_ack", 8'hA5);
      check("stop_one_cycle", stop_cycles - s0, 1);

      p0 = tx_pulses;
      send(8'h06);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(8);
      check("rst_mid_tx_no_reply", tx_pulses - p0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
